// File: rtl/raster_engine.sv
// Scanline-free triangle rasterizer: optional clear pass, then per-triangle bounding-box walk
// with edge-function coverage and a strict less-than depth test against an external z-buffer.
module raster_engine #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int COORD_BITS            = 8,
    parameter int DEPTH_BITS            = 16,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int VRAM_ADDR_BITS        = 8,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT),
    parameter int TRI_BITS              = 6*COORD_BITS+DEPTH_BITS+FRAMEBUFFER_DATA_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic [VRAM_ADDR_BITS:0]          tri_count,
    input  logic                             clear_en,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] clear_color,
    output logic                             busy,
    output logic                             frame_done,
    output logic [VRAM_ADDR_BITS-1:0]        vram_rd_addr,
    input  logic [TRI_BITS-1:0]              vram_rd_data,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] zbuf_rd_addr,
    input  logic [DEPTH_BITS-1:0]            zbuf_rd_data,
    output logic                             zbuf_wr_en,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] zbuf_wr_addr,
    output logic [DEPTH_BITS-1:0]            zbuf_wr_data,
    output logic                             fb_wr_valid,
    input  logic                             fb_wr_ready,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_wr_addr,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] fb_wr_data
);
    localparam int CB  = COORD_BITS;
    localparam int FBA = FRAMEBUFFER_ADDR_BITS;
    localparam int EW  = 2*COORD_BITS+4;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, LOAD, SETUP, RASTER_READ, RASTER_WRITE, DONE
    } state_t;

    state_t                      r_state, w_next;
    logic [VRAM_ADDR_BITS:0]     r_idx, r_cnt;
    logic [FBA-1:0]              r_clr_addr;
    logic [TRI_BITS-1:0]         r_tri;
    logic [CB-1:0]               r_x, r_y, r_min_x, r_max_x, r_max_y;

    function automatic logic signed [EW-1:0] edge_fn(input logic [CB-1:0] x0, y0, x1, y1, px, py);
        logic signed [EW-1:0] dx, dy, qx, qy;
        dx = $signed(EW'(x1)) - $signed(EW'(x0));
        dy = $signed(EW'(y1)) - $signed(EW'(y0));
        qx = $signed(EW'(px)) - $signed(EW'(x0));
        qy = $signed(EW'(py)) - $signed(EW'(y0));
        return dx*qy - dy*qx;
    endfunction

    function automatic logic [CB-1:0] min3(input logic [CB-1:0] a, b, c);
        logic [CB-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CB-1:0] max3(input logic [CB-1:0] a, b, c);
        logic [CB-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic [CB-1:0]                    w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
    logic [CB-1:0]                    w_bmin_x, w_bmin_y, w_bmax_x, w_bmax_y, w_cmax_x, w_cmax_y;
    logic [DEPTH_BITS-1:0]            w_depth;
    logic [FRAMEBUFFER_DATA_BITS-1:0] w_color;
    logic signed [EW-1:0]             w_area, w_e_ab, w_e_bc, w_e_ca;
    logic                             w_bbox_ok, w_covered, w_write, w_last_pix, w_clr_last;
    logic [FBA-1:0]                   w_pix_addr;

    assign w_ax    = r_tri[0*CB +: CB];
    assign w_ay    = r_tri[1*CB +: CB];
    assign w_bx    = r_tri[2*CB +: CB];
    assign w_by    = r_tri[3*CB +: CB];
    assign w_cx    = r_tri[4*CB +: CB];
    assign w_cy    = r_tri[5*CB +: CB];
    assign w_depth = r_tri[6*CB +: DEPTH_BITS];
    assign w_color = r_tri[6*CB+DEPTH_BITS +: FRAMEBUFFER_DATA_BITS];

    // Only the max edge needs clamping: an off-screen min then exceeds the clamped max.
    assign w_bmin_x  = min3(w_ax, w_bx, w_cx);
    assign w_bmin_y  = min3(w_ay, w_by, w_cy);
    assign w_bmax_x  = max3(w_ax, w_bx, w_cx);
    assign w_bmax_y  = max3(w_ay, w_by, w_cy);
    assign w_cmax_x  = (32'(w_bmax_x) > 32'(DISPLAY_WIDTH-1))  ? CB'(DISPLAY_WIDTH-1)  : w_bmax_x;
    assign w_cmax_y  = (32'(w_bmax_y) > 32'(DISPLAY_HEIGHT-1)) ? CB'(DISPLAY_HEIGHT-1) : w_bmax_y;
    assign w_bbox_ok = (w_bmin_x <= w_cmax_x) && (w_bmin_y <= w_cmax_y);
    assign w_area    = edge_fn(w_ax, w_ay, w_bx, w_by, w_cx, w_cy);

    assign w_e_ab = edge_fn(w_ax, w_ay, w_bx, w_by, r_x, r_y);
    assign w_e_bc = edge_fn(w_bx, w_by, w_cx, w_cy, r_x, r_y);
    assign w_e_ca = edge_fn(w_cx, w_cy, w_ax, w_ay, r_x, r_y);
    assign w_covered = (!w_e_ab[EW-1] && !w_e_bc[EW-1] && !w_e_ca[EW-1]) ||
                       ((w_e_ab[EW-1] || w_e_ab == '0) && (w_e_bc[EW-1] || w_e_bc == '0) &&
                        (w_e_ca[EW-1] || w_e_ca == '0));
    // zbuf_rd_addr is held through RASTER_WRITE so zbuf_rd_data stays valid across a stall.
    assign w_write    = w_covered && (w_depth < zbuf_rd_data);
    assign w_pix_addr = FBA'(32'(r_x) + 32'(DISPLAY_WIDTH) * 32'(r_y));
    assign w_last_pix = (r_x == r_max_x) && (r_y == r_max_y);
    assign w_clr_last = (r_clr_addr == FBA'(DISPLAY_WIDTH*DISPLAY_HEIGHT-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         if (frame_start) w_next = clear_en ? CLEAR : FETCH;
            CLEAR:        if (fb_wr_ready && w_clr_last) w_next = FETCH;
            FETCH:        w_next = (r_idx == r_cnt) ? DONE : LOAD;
            LOAD:         w_next = SETUP;
            SETUP:        w_next = (w_area == '0 || !w_bbox_ok) ? FETCH : RASTER_READ;
            RASTER_READ:  w_next = RASTER_WRITE;
            RASTER_WRITE: if (!w_write || fb_wr_ready) w_next = w_last_pix ? FETCH : RASTER_READ;
            DONE:         w_next = IDLE;
            default:      w_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != IDLE);
        frame_done   = 1'b0;
        vram_rd_addr = '0;
        zbuf_rd_addr = '0;
        zbuf_wr_en   = 1'b0;
        zbuf_wr_addr = '0;
        zbuf_wr_data = '0;
        fb_wr_valid  = 1'b0;
        fb_wr_addr   = '0;
        fb_wr_data   = '0;
        case (r_state)
            CLEAR: begin
                fb_wr_valid  = 1'b1;
                fb_wr_addr   = r_clr_addr;
                fb_wr_data   = clear_color;
                zbuf_wr_en   = fb_wr_ready;
                zbuf_wr_addr = r_clr_addr;
                zbuf_wr_data = '1;
            end
            FETCH:       vram_rd_addr = r_idx[VRAM_ADDR_BITS-1:0];
            RASTER_READ: zbuf_rd_addr = w_pix_addr;
            RASTER_WRITE: begin
                zbuf_rd_addr = w_pix_addr;
                if (w_write) begin
                    fb_wr_valid  = 1'b1;
                    fb_wr_addr   = w_pix_addr;
                    fb_wr_data   = w_color;
                    zbuf_wr_en   = fb_wr_ready;
                    zbuf_wr_addr = w_pix_addr;
                    zbuf_wr_data = w_depth;
                end
            end
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_clr_addr <= '0;
            r_tri      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_min_x    <= '0;
            r_max_x    <= '0;
            r_max_y    <= '0;
        end else begin
            case (r_state)
                IDLE: if (frame_start) begin
                    r_idx      <= '0;
                    r_cnt      <= tri_count;
                    r_clr_addr <= '0;
                end
                CLEAR: if (fb_wr_ready) r_clr_addr <= r_clr_addr + 1'b1;
                LOAD: begin
                    r_tri <= vram_rd_data;
                    r_idx <= r_idx + 1'b1;
                end
                SETUP: begin
                    r_x     <= w_bmin_x;
                    r_y     <= w_bmin_y;
                    r_min_x <= w_bmin_x;
                    r_max_x <= w_cmax_x;
                    r_max_y <= w_cmax_y;
                end
                RASTER_WRITE: if (!w_write || fb_wr_ready) begin
                    if (r_x == r_max_x) begin
                        r_x <= r_min_x;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
